// File: rtl/icache_refill_ctrl.sv
// Miss-side refill controller for the instruction cache: picks a victim way,
// fetches the line from memory into the data array, then publishes tag and status.
module icache_refill_ctrl #(
  parameter int SET_BITS_WIDTH = 4,
  parameter int TAG_WIDTH      = 8,
  parameter int NUM_WAYS       = 4,
  parameter int LINE_BEATS     = 4,
  parameter int BEAT_WIDTH     = 32,
  localparam int TA_WORD_WIDTH = TAG_WIDTH * NUM_WAYS,
  localparam int SA_WORD_WIDTH = 2 * NUM_WAYS,
  localparam int BEAT_BITS     = $clog2(LINE_BEATS)
) (
  input  logic                                  clk,
  input  logic                                  arst_n,
  input  logic                                  i_halt,
  input  logic [SET_BITS_WIDTH-1:0]             i_miss_set_addr,
  input  logic [TAG_WIDTH-1:0]                  i_miss_tag,
  input  logic [SA_WORD_WIDTH-1:0]              i_miss_sa_data,
  input  logic                                  i_miss_valid,
  output logic                                  o_miss_ready,
  output logic                                  o_miss_state,
  output logic [TAG_WIDTH+SET_BITS_WIDTH-1:0]   o_mem_req_addr,
  output logic                                  o_mem_req_valid,
  input  logic                                  i_mem_req_ready,
  input  logic [BEAT_WIDTH-1:0]                 i_mem_rsp_data,
  input  logic                                  i_mem_rsp_valid,
  output logic                                  o_mem_rsp_ready,
  output logic [SET_BITS_WIDTH+2+BEAT_BITS-1:0] o_w_da_addr,
  output logic [BEAT_WIDTH-1:0]                 o_w_da_data,
  output logic                                  o_w_da_valid,
  output logic [SET_BITS_WIDTH-1:0]             o_w_ta_set_addr,
  output logic [TA_WORD_WIDTH-1:0]              o_w_ta_data,
  output logic [NUM_WAYS-1:0]                   o_w_ta_mask,
  output logic                                  o_w_ta_valid,
  output logic [SET_BITS_WIDTH-1:0]             o_w_sa_set_addr,
  output logic [SA_WORD_WIDTH-1:0]              o_w_sa_data,
  output logic [NUM_WAYS-1:0]                   o_w_sa_mask,
  output logic                                  o_w_sa_valid,
  output logic                                  o_fill_done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_FILL   = 2'd2;
  localparam logic [1:0] ST_UPDATE = 2'd3;

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_BEATS - 1);

  logic [1:0]                state_r;
  logic [SET_BITS_WIDTH-1:0] set_r;
  logic [TAG_WIDTH-1:0]      tag_r;
  logic [NUM_WAYS-1:0]       valid_r;
  logic [1:0]                way_r;
  logic [1:0]                rr_ptr_r;
  logic [BEAT_BITS-1:0]      beat_cnt_r;

  logic [1:0]                victim_s;
  logic                      inv_found_s;
  logic [NUM_WAYS-1:0]       miss_valid_bits_s;
  logic [NUM_WAYS-1:0]       mru_unused_s;
  logic                      beat_acc_s;
  logic                      update_s;
  logic [SA_WORD_WIDTH-1:0]  sa_upd_s;

  // Split the incoming status word into valid and mru fields per way.
  always_comb begin
    miss_valid_bits_s = '0;
    mru_unused_s      = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      miss_valid_bits_s[w] = i_miss_sa_data[2*w+1];
      mru_unused_s[w]      = i_miss_sa_data[2*w];
    end
  end

  // Victim choice: lowest invalid way wins, otherwise the round-robin pointer.
  always_comb begin
    victim_s    = rr_ptr_r;
    inv_found_s = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!miss_valid_bits_s[w]) begin
        victim_s    = 2'(w);
        inv_found_s = 1'b1;
      end else begin
        victim_s    = victim_s;
        inv_found_s = inv_found_s;
      end
    end
  end

  assign beat_acc_s = i_mem_rsp_valid & o_mem_rsp_ready;
  assign update_s   = (state_r == ST_UPDATE) & ~i_halt;

  // Refill sequencing; a halted pipeline freezes every register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r    <= ST_IDLE;
      set_r      <= '0;
      tag_r      <= '0;
      valid_r    <= '0;
      way_r      <= 2'd0;
      rr_ptr_r   <= 2'd0;
      beat_cnt_r <= '0;
    end else if (!i_halt) begin
      case (state_r)
        ST_IDLE: begin
          if (i_miss_valid) begin
            state_r <= ST_REQ;
            set_r   <= i_miss_set_addr;
            tag_r   <= i_miss_tag;
            valid_r <= miss_valid_bits_s;
            way_r   <= victim_s;
            if (!inv_found_s) begin
              rr_ptr_r <= rr_ptr_r + 2'd1;
            end
          end
        end
        ST_REQ: begin
          if (i_mem_req_ready) begin
            state_r    <= ST_FILL;
            beat_cnt_r <= '0;
          end
        end
        ST_FILL: begin
          if (i_mem_rsp_valid) begin
            beat_cnt_r <= beat_cnt_r + BEAT_BITS'(1);
            if (beat_cnt_r == LAST_BEAT) begin
              state_r <= ST_UPDATE;
            end
          end
        end
        ST_UPDATE: state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

  // Victim becomes valid+mru; every other way keeps its valid bit and loses mru.
  always_comb begin
    sa_upd_s = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (2'(w) == way_r) begin
        sa_upd_s[2*w +: 2] = 2'b11;
      end else begin
        sa_upd_s[2*w +: 2] = {valid_r[w], 1'b0};
      end
    end
  end

  assign o_miss_ready    = (state_r == ST_IDLE) & ~i_halt;
  assign o_miss_state    = (state_r != ST_IDLE);
  assign o_mem_req_addr  = {tag_r, set_r};
  assign o_mem_req_valid = (state_r == ST_REQ) & ~i_halt;
  assign o_mem_rsp_ready = (state_r == ST_FILL) & ~i_halt;

  assign o_w_da_addr  = {set_r, way_r, beat_cnt_r};
  assign o_w_da_data  = i_mem_rsp_data;
  assign o_w_da_valid = beat_acc_s;

  assign o_w_ta_set_addr = set_r;
  assign o_w_ta_data     = {NUM_WAYS{tag_r}};
  assign o_w_ta_mask     = {{(NUM_WAYS-1){1'b0}}, 1'b1} << way_r;
  assign o_w_ta_valid    = update_s;

  assign o_w_sa_set_addr = set_r;
  assign o_w_sa_data     = sa_upd_s;
  assign o_w_sa_mask     = {NUM_WAYS{1'b1}};
  assign o_w_sa_valid    = update_s;

  assign o_fill_done = update_s;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: stimulus pushes expected array writes,
// a negedge monitor pops and compares them and tracks handshake/strobe levels.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        i_halt;
  logic [3:0]  i_miss_set_addr;
  logic [7:0]  i_miss_tag;
  logic [7:0]  i_miss_sa_data;
  logic        i_miss_valid;
  logic        o_miss_ready;
  logic        o_miss_state;
  logic [11:0] o_mem_req_addr;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] i_mem_rsp_data;
  logic        i_mem_rsp_valid;
  logic        o_mem_rsp_ready;
  logic [7:0]  o_w_da_addr;
  logic [31:0] o_w_da_data;
  logic        o_w_da_valid;
  logic [3:0]  o_w_ta_set_addr;
  logic [31:0] o_w_ta_data;
  logic [3:0]  o_w_ta_mask;
  logic        o_w_ta_valid;
  logic [3:0]  o_w_sa_set_addr;
  logic [7:0]  o_w_sa_data;
  logic [3:0]  o_w_sa_mask;
  logic        o_w_sa_valid;
  logic        o_fill_done;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk(clk), .arst_n(arst_n), .i_halt(i_halt),
    .i_miss_set_addr(i_miss_set_addr), .i_miss_tag(i_miss_tag),
    .i_miss_sa_data(i_miss_sa_data), .i_miss_valid(i_miss_valid),
    .o_miss_ready(o_miss_ready), .o_miss_state(o_miss_state),
    .o_mem_req_addr(o_mem_req_addr), .o_mem_req_valid(o_mem_req_valid),
    .i_mem_req_ready(i_mem_req_ready), .i_mem_rsp_data(i_mem_rsp_data),
    .i_mem_rsp_valid(i_mem_rsp_valid), .o_mem_rsp_ready(o_mem_rsp_ready),
    .o_w_da_addr(o_w_da_addr), .o_w_da_data(o_w_da_data), .o_w_da_valid(o_w_da_valid),
    .o_w_ta_set_addr(o_w_ta_set_addr), .o_w_ta_data(o_w_ta_data),
    .o_w_ta_mask(o_w_ta_mask), .o_w_ta_valid(o_w_ta_valid),
    .o_w_sa_set_addr(o_w_sa_set_addr), .o_w_sa_data(o_w_sa_data),
    .o_w_sa_mask(o_w_sa_mask), .o_w_sa_valid(o_w_sa_valid),
    .o_fill_done(o_fill_done)
  );

  logic [39:0] exp_da_q[$];   // {addr, data}
  logic [55:0] exp_upd_q[$];  // {ta_set, ta_data, ta_mask, sa_set, sa_data, sa_mask}
  logic [11:0] exp_req_q[$];
  int          total = 0;
  int          bad = 0;
  logic [1:0]  exp_st;        // 0 idle, 1 req, 2 fill, 3 update
  logic        final_chk;
  logic        final_done = 1'b0;

  function automatic logic [31:0] beat_data(input logic [7:0] tag, input logic [3:0] set, input int b);
    return {8'hD0 + 8'(b), tag, 4'h0, set, 8'(b)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: level checks every cycle, payload checks whenever a strobe fires.
  always @(negedge clk) begin
    logic       h;
    logic       u;
    logic [7:0] ctl_a;
    logic [7:0] ctl_e;
    ctl_a = {o_miss_ready, o_miss_state, o_mem_req_valid, o_mem_rsp_ready,
             o_w_da_valid, o_w_ta_valid, o_w_sa_valid, o_fill_done};
    if (!arst_n) begin
      ctl_e = {~i_halt, 7'b0};
      chk("reset_outputs", 64'(ctl_a), 64'(ctl_e));
    end else begin
      h = i_halt;
      u = (exp_st == 2'd3) & ~h;
      ctl_e = {(exp_st == 2'd0) & ~h, exp_st != 2'd0, (exp_st == 2'd1) & ~h,
               (exp_st == 2'd2) & ~h, (exp_st == 2'd2) & ~h & i_mem_rsp_valid, u, u, u};
      chk("control", 64'(ctl_a), 64'(ctl_e));
      if (o_mem_req_valid) begin
        if (exp_req_q.size() == 0) begin
          chk("req_unexpected", 64'(o_mem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("req_addr", 64'(o_mem_req_addr), 64'(exp_req_q[0]));
          if (i_mem_req_ready) void'(exp_req_q.pop_front());
        end
      end
      if (o_w_da_valid) begin
        if (exp_da_q.size() == 0) begin
          chk("da_unexpected", 64'({o_w_da_addr, o_w_da_data}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("da_write", 64'({o_w_da_addr, o_w_da_data}), 64'(exp_da_q.pop_front()));
        end
      end
      if (o_w_ta_valid) begin
        if (exp_upd_q.size() == 0) begin
          chk("upd_unexpected", 64'(o_w_ta_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("tag_status_write",
              64'({o_w_ta_set_addr, o_w_ta_data, o_w_ta_mask, o_w_sa_set_addr, o_w_sa_data, o_w_sa_mask}),
              64'(exp_upd_q.pop_front()));
        end
      end
      if (final_chk && !final_done) begin
        chk("queues_drained", 64'(exp_da_q.size() + exp_upd_q.size() + exp_req_q.size()), 64'd0);
        final_done = 1'b1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One miss; nb < 4 pulses reset after nb beats, halt_beat >= 0 freezes 3 cycles there.
  task automatic do_miss(input logic [3:0] set, input logic [7:0] tag, input logic [7:0] sa,
                         input logic [1:0] way, input logic [7:0] sa_exp,
                         input int req_stall, input int halt_beat, input int nb,
                         input logic nxt_en, input logic [3:0] nxt_set,
                         input logic [7:0] nxt_tag, input logic [7:0] nxt_sa);
    logic [3:0] mask;
    logic       ok;
    mask = 4'b0001 << way;
    exp_req_q.push_back({tag, set});
    for (int b = 0; b < nb; b++) exp_da_q.push_back({set, way, 2'(b), beat_data(tag, set, b)});
    if (nb == 4) exp_upd_q.push_back({set, {4{tag}}, mask, set, sa_exp, 4'b1111});
    i_miss_set_addr = set;
    i_miss_tag      = tag;
    i_miss_sa_data  = sa;
    i_miss_valid    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_miss_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL miss_accept_timeout set=%0h tag=%0h", set, tag);
      $fatal(1, "timeout");
    end
    tick;
    i_miss_valid = 1'b0;
    exp_st = 2'd1;
    repeat (req_stall) tick;
    i_mem_req_ready = 1'b1;
    tick;
    i_mem_req_ready = 1'b0;
    exp_st = 2'd2;
    if (nxt_en) begin
      i_miss_set_addr = nxt_set;
      i_miss_tag      = nxt_tag;
      i_miss_sa_data  = nxt_sa;
      i_miss_valid    = 1'b1;
    end
    for (int b = 0; b < nb; b++) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = beat_data(tag, set, b);
      if (b == halt_beat) begin
        i_halt = 1'b1;
        repeat (3) tick;
        i_halt = 1'b0;
      end
      tick;
    end
    i_mem_rsp_valid = 1'b0;
    if (nb == 4) begin
      exp_st = 2'd3;
      tick;
      exp_st = 2'd0;
    end else begin
      arst_n = 1'b0;
      exp_st = 2'd0;
      tick;
      arst_n = 1'b1;
    end
  endtask

  initial begin
    arst_n = 1'b0; i_halt = 1'b0; i_miss_valid = 1'b0;
    i_miss_set_addr = 4'h0; i_miss_tag = 8'h00; i_miss_sa_data = 8'h00;
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = 32'h0;
    exp_st = 2'd0; final_chk = 1'b0;
    repeat (2) tick;
    arst_n = 1'b1;
    tick;
    // pending miss while halted in IDLE must not be taken
    i_halt = 1'b1; i_miss_valid = 1'b1; i_miss_set_addr = 4'h3; i_miss_tag = 8'hA5;
    repeat (2) tick;
    i_halt = 1'b0; i_miss_valid = 1'b0;
    // empty set; next miss presented during the fill
    do_miss(4'h3, 8'hA5, 8'h00, 2'd0, 8'h03, 0, -1, 4, 1'b1, 4'h7, 8'h3C, 8'h2A);
    // partial valid -> way3, with a 5-cycle request stall
    do_miss(4'h7, 8'h3C, 8'h2A, 2'd3, 8'hEA, 5, -1, 4, 1'b0, 4'h0, 8'h00, 8'h00);
    // all valid: round-robin way0 (halt mid-fill), then way1
    do_miss(4'h9, 8'h11, 8'hFF, 2'd0, 8'hAB, 0, 2, 4, 1'b0, 4'h0, 8'h00, 8'h00);
    do_miss(4'h9, 8'h22, 8'hFF, 2'd1, 8'hAE, 0, -1, 4, 1'b0, 4'h0, 8'h00, 8'h00);
    // all valid -> way2, reset after two beats
    do_miss(4'h2, 8'h33, 8'hFF, 2'd2, 8'h00, 0, -1, 2, 1'b0, 4'h0, 8'h00, 8'h00);
    // pointer back at 0 after reset
    do_miss(4'h2, 8'h44, 8'hFF, 2'd0, 8'hAB, 0, -1, 4, 1'b0, 4'h0, 8'h00, 8'h00);
    final_chk = 1'b1;
    repeat (2) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
